mulmod_lanes_pipe: RTL and testbench
====================================

// Module: mulmod_lanes_pipe
// PURPOSE
// Multi-lane, fully pipelined modular arithmetic unit for the NTT/FFT datapath.
// Computes a*b mod p by Barrett reduction, plus modular add/sub, selected per beat.
// Adds valid/ready flow control, a runtime-loadable modulus and a tag passthrough.
// Sits between the butterfly scheduler and the coefficient memory write-back.
// PARAMETERS
// DATA_WIDTH  14  operand/modulus width W; p must satisfy 2^(W-1) <= p < 2^W
// LANES       4   independent lanes sharing one modulus and one handshake
// TAG_WIDTH   8   opaque sideband carried alongside each beat
// PORTS
// clk        input   1               clock, all logic rising-edge
// rst        input   1               synchronous reset, active-high
// cfg_we     input   1               load modulus/mu (accepted only when cfg_ready)
// cfg_p      input   W               modulus p
// cfg_mu     input   W+1             floor(2^(2W)/p)
// cfg_ready  output  1               high when pipeline is empty
// in_valid   input   1               beat present
// in_ready   output  1               beat accepted when in_valid && in_ready
// in_mode    input   2               0=MUL 1=ADD 2=SUB 3=reserved (treated as MUL, err)
// in_a       input   LANES*W         lane i at [i*W +: W]
// in_b       input   LANES*W         same packing
// in_tag     input   TAG_WIDTH       sideband
// out_valid  output  1               result beat present
// out_ready  input   1               downstream accepts
// out_res    output  LANES*W         results, same packing
// out_tag    output  TAG_WIDTH       tag of that beat
// out_err    output  LANES           lane operand >= p, or mode 3
// BEHAVIOUR
// - Reset: all stage valids 0; out_valid=0, out_res=0, out_tag=0, out_err=0;
//   p=0, mu=0; cfg_ready=1; in_ready=1. Reset mid-operation drops all in-flight beats.
// - Fixed latency 4 stages. Global advance en = !out_valid || out_ready; in_ready = en.
//   Accepted beat appears on out_valid exactly 4 cycles later when out_ready is held high.
// - Stall: out_valid && !out_ready freezes every stage; out_* stay stable; no beat lost or duplicated.
// - Bubbles propagate as invalid stages; pipeline fills and drains one stage per en cycle.
// - Stages:
//   S1 register a, b, mode, tag; compute err.
//   S2 MUL: S = a*b (2W); ADD: s = a+b; SUB: s = a-b+p.
//   S3 MUL: q = ((S >> (W-1)) * mu) >> (W+1).
//   S4 MUL: r = S - q*p, kept in W+2 bits; then subtract p up to twice while r >= p.
//      ADD/SUB: subtract p once if s >= p.
// - ADD/SUB ride the same stages with registered bypass, so beat order is preserved for all modes.
// - Results are exact for a, b < p. For err lanes out_res is don't-care but deterministic
//   (the same datapath output); err is flagged per lane.
// - Config: cfg_we && cfg_ready latches p, mu in one cycle. cfg_ready = no stage valid && !in_valid.
//   cfg_we while !cfg_ready is ignored.
// - Simultaneous cfg_we and in_valid: cfg_ready=0, so the config is dropped and the beat proceeds.
// - Modulus is never changed under an in-flight beat.
// STRUCTURE
// - mulmod_pkg: mode_e enum (MODE_MUL, MODE_ADD, MODE_SUB), MULMOD_LAT=4 constant,
//   barrett_q/r width localparams.
// - Sub-module barrett_lane: one lane's S1..S4 datapath with en input, instantiated LANES times.
// - Top holds the valid/tag/mode shift chain, the handshake and the config registers.
// TESTING (W=14, p=12289, mu=21843)
// - Reset then load cfg: cfg_we=1 -> cfg_ready stays 1; a later MUL uses p=12289.
// - MUL a=12288, b=12288 all lanes, out_ready=1 -> out_res lanes=1, out_valid exactly 4 cycles after accept.
// - MUL a=5000, b=7000 -> 928. ADD 12000+1000 -> 711. SUB 5-10 -> 12284.
//   Issued back-to-back with tags 1,2,3; outputs appear in order with matching tags.
// - Stall: 6 back-to-back beats, out_ready low 3 cycles mid-stream
//   -> outputs stable while stalled, all 6 delivered once, in order.
// - Config guard: cfg_we with a beat in flight -> ignored, old p still used;
//   cfg_we after drain -> accepted.
// - Lane 2 a=12289 (>=p) -> out_err=4'b0100. Mode 3 -> out_err=4'b1111.
//   rst mid-stream -> out_valid=0 next cycle, no stale beats emerge.

Source files
------------

// File: rtl/mulmod_pkg.sv
// rtl/mulmod_pkg.sv - shared types and constants for the lane-parallel Barrett mulmod pipeline
package mulmod_pkg;

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_ADD = 2'd1,
    MODE_SUB = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  localparam int MULMOD_LAT = 4;

  // Barrett quotient needs W+1 bits; the pre-correction remainder is below 3p, so W+2 bits suffice.
  localparam int BARRETT_Q_EXTRA = 1;
  localparam int BARRETT_R_EXTRA = 2;

endpackage

// File: rtl/mulmod_lanes_pipe_barrett_lane.sv
// rtl/mulmod_lanes_pipe_barrett_lane.sv - one lane of the four-stage Barrett mul / add / sub datapath
module barrett_lane
  import mulmod_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] p_i,
  input  logic [W:0]   mu_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  mode_e        mode_s1_i,
  input  mode_e        mode_s3_i,
  output logic [W-1:0] res_o,
  output logic         err_o
);

  localparam int QW = W + BARRETT_Q_EXTRA;
  localparam int RW = W + BARRETT_R_EXTRA;

  logic [W-1:0]   a1_q, b1_q;
  logic [3:0]     err_q;
  logic [2*W-1:0] prod2_q, prod2_d;
  logic [RW-1:0]  prod3_q;
  logic [QW-1:0]  q3_q, q3_d;
  logic [W-1:0]   res4_q, res4_d;
  logic           err1_d;

  logic [RW-1:0]  pext, r0, r1, r2, ras;

  assign err1_d = (a_i >= p_i) || (b_i >= p_i);

  always_comb begin
    prod2_d = '0;
    case (mode_s1_i)
      MODE_ADD: prod2_d = {{(W-1){1'b0}}, {1'b0, a1_q} + {1'b0, b1_q}};
      MODE_SUB: prod2_d = {{(W-1){1'b0}}, {1'b0, a1_q} + {1'b0, p_i} - {1'b0, b1_q}};
      default:  prod2_d = {{W{1'b0}}, a1_q} * {{W{1'b0}}, b1_q};
    endcase
  end

  assign q3_d = QW'(({{QW{1'b0}}, prod2_q[2*W-1:W-1]} * {{QW{1'b0}}, mu_i}) >> (W + 1));

  // Only the low W+2 bits of S - q*p matter since the true difference is below 3p.
  assign pext = {2'b00, p_i};
  assign r0   = prod3_q - ({1'b0, q3_q} * pext);

  always_comb begin
    r1     = (r0 >= pext) ? (r0 - pext) : r0;
    r2     = (r1 >= pext) ? (r1 - pext) : r1;
    ras    = (prod3_q >= pext) ? (prod3_q - pext) : prod3_q;
    res4_d = r2[W-1:0];
    if (mode_s3_i == MODE_ADD || mode_s3_i == MODE_SUB) begin
      res4_d = ras[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q    <= '0;
      b1_q    <= '0;
      err_q   <= '0;
      prod2_q <= '0;
      prod3_q <= '0;
      q3_q    <= '0;
      res4_q  <= '0;
    end else if (en) begin
      a1_q    <= a_i;
      b1_q    <= b_i;
      err_q   <= {err_q[2:0], err1_d};
      prod2_q <= prod2_d;
      prod3_q <= prod2_q[RW-1:0];
      q3_q    <= q3_d;
      res4_q  <= res4_d;
    end
  end

  assign res_o = res4_q;
  assign err_o = err_q[3];

endmodule

// File: rtl/mulmod_lanes_pipe.sv
// rtl/mulmod_lanes_pipe.sv - multi-lane pipelined modular mul/add/sub with handshake and loadable modulus
module mulmod_lanes_pipe
  import mulmod_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int LANES      = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [DATA_WIDTH-1:0]       cfg_p,
  input  logic [DATA_WIDTH:0]         cfg_mu,
  output logic                        cfg_ready,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_mode,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_res,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic [LANES-1:0]            out_err
);

  localparam int L = MULMOD_LAT;

  logic [L-1:0]          vld_q, vld_d;
  mode_e                 mode_q [L];
  logic [TAG_WIDTH-1:0]  tag_q  [L];
  logic [DATA_WIDTH-1:0] p_q, p_d;
  logic [DATA_WIDTH:0]   mu_q, mu_d;
  logic [LANES-1:0]      lane_err;
  logic                  en;

  // One global enable: the whole pipe freezes while the output beat is held.
  assign en        = !vld_q[L-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[L-1];
  assign cfg_ready = !(|vld_q) && !in_valid;

  always_comb begin
    vld_d = vld_q;
    p_d   = p_q;
    mu_d  = mu_q;
    if (en) begin
      vld_d = {vld_q[L-2:0], in_valid};
    end
    if (cfg_we && cfg_ready) begin
      p_d  = cfg_p;
      mu_d = cfg_mu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      p_q   <= '0;
      mu_q  <= '0;
      for (int i = 0; i < L; i++) begin
        mode_q[i] <= MODE_MUL;
        tag_q[i]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      p_q   <= p_d;
      mu_q  <= mu_d;
      if (en) begin
        mode_q[0] <= mode_e'(in_mode);
        tag_q[0]  <= in_tag;
        for (int i = 1; i < L; i++) begin
          mode_q[i] <= mode_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    barrett_lane #(.W(DATA_WIDTH)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .p_i       (p_q),
      .mu_i      (mu_q),
      .a_i       (in_a[g*DATA_WIDTH +: DATA_WIDTH]),
      .b_i       (in_b[g*DATA_WIDTH +: DATA_WIDTH]),
      .mode_s1_i (mode_q[0]),
      .mode_s3_i (mode_q[2]),
      .res_o     (out_res[g*DATA_WIDTH +: DATA_WIDTH]),
      .err_o     (lane_err[g])
    );
  end

  assign out_tag = tag_q[L-1];
  assign out_err = lane_err | {LANES{mode_q[L-1] == MODE_RSV}};

endmodule

// File: tb/tb_mulmod_lanes_pipe.sv
// tb/tb_mulmod_lanes_pipe.sv - table-driven self-checking bench for mulmod_lanes_pipe
module tb_mulmod_lanes_pipe;

  localparam int W  = 14;
  localparam int NL = 4;
  localparam int TW = 8;

  logic            clk, rst, cfg_we, cfg_ready;
  logic [W-1:0]    cfg_p;
  logic [W:0]      cfg_mu;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      in_mode;
  logic [NL*W-1:0] in_a, in_b, out_res;
  logic [TW-1:0]   in_tag, out_tag;
  logic [NL-1:0]   out_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]      mode;
    logic [NL*W-1:0] a;
    logic [NL*W-1:0] b;
    logic [NL*W-1:0] res;
    logic [NL-1:0]   err;
    logic [NL-1:0]   mask;
  } vec_t;

  vec_t tbl [8];

  mulmod_lanes_pipe #(.DATA_WIDTH(W), .LANES(NL), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_p(cfg_p), .cfg_mu(cfg_mu),
    .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_tag(out_tag), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NL*W-1:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {W'(x3), W'(x2), W'(x1), W'(x0)};
  endfunction

  function automatic logic [NL*W-1:0] lmask(input logic [NL-1:0] m);
    logic [NL*W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*W +: W] = {W{m[i]}};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic drive_beat(input int idx);
    in_mode = tbl[idx].mode;
    in_a    = tbl[idx].a;
    in_b    = tbl[idx].b;
    in_tag  = TW'(idx + 1);
  endtask

  task automatic check_out(input int idx, input string pfx);
    chk({pfx, "_res"}, 64'(out_res & lmask(tbl[idx].mask)), 64'(tbl[idx].res & lmask(tbl[idx].mask)));
    chk({pfx, "_tag"}, 64'(out_tag), 64'(idx + 1));
    chk({pfx, "_err"}, 64'(out_err), 64'(tbl[idx].err));
  endtask

  task automatic load_cfg(input int p, input int mu);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_p = W'(p); cfg_mu = (W+1)'(mu);
    #1 chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Streams tbl[first..first+n-1]; optional output stall window; optional cfg_we pulse (alternate modulus) at cfg_at.
  task automatic run_beats(input int first, input int n, input int stall_at, input int stall_len, input int cfg_at);
    int sent, got, cyc, stale;
    int q[$];
    sent = 0; got = 0; cyc = 0; stale = 0;
    while (got < n && cyc < 200) begin
      @(posedge clk); #1;
      out_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (sent < n);
      if (sent < n) drive_beat(first + sent);
      cfg_we = (cyc == cfg_at);
      cfg_p  = W'(16383); cfg_mu = (W+1)'(16385);
      #1;
      if (cyc == cfg_at) chk("cfg_ready_busy", 64'(cfg_ready), 64'd0);
      if (out_valid) begin
        if (q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
        else begin
          check_out(q[0], "beat");
          if (!out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
          else begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(first + sent);
        sent++;
      end
      cyc++;
    end
    if (got < n) chk("timeout_beats", 64'(got), 64'(n));
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("no_dup_after_drain", 64'(stale), 64'd0);
  endtask

  initial begin
    int lat, stale;
    tbl[0] = '{2'd0, pk(12288,12288,12288,12288), pk(12288,12288,12288,12288), pk(1,1,1,1),          4'b0000, 4'b1111};
    tbl[1] = '{2'd0, pk(5000,2,100,12288),        pk(7000,6145,200,12288),     pk(928,1,7711,1),     4'b0000, 4'b1111};
    tbl[2] = '{2'd1, pk(12000,12288,0,1),         pk(1000,12288,0,2),          pk(711,12287,0,3),    4'b0000, 4'b1111};
    tbl[3] = '{2'd2, pk(5,0,12288,10),            pk(10,0,0,5),                pk(12284,0,12288,5),  4'b0000, 4'b1111};
    tbl[4] = '{2'd0, pk(0,1,12288,3),             pk(9999,12288,2,4),          pk(0,12288,12287,12), 4'b0000, 4'b1111};
    tbl[5] = '{2'd0, pk(3,5000,12289,1),          pk(4,7000,1,1),              pk(12,928,0,1),       4'b0100, 4'b1011};
    tbl[6] = '{2'd3, pk(3,5000,2,100),            pk(4,7000,6145,200),         pk(12,928,1,7711),    4'b1111, 4'b1111};
    tbl[7] = '{2'd0, pk(16382,128,200,3),         pk(16382,128,100,5),         pk(1,1,3617,15),      4'b0000, 4'b1111};

    rst = 1'b1; cfg_we = 1'b0; cfg_p = '0; cfg_mu = '0;
    in_valid = 1'b0; in_mode = '0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_res",   64'(out_res),   64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;

    load_cfg(12289, 21843);

    // Single beat: out_valid must rise on the 4th edge counting the accepting edge.
    @(posedge clk); #1;
    in_valid = 1'b1; drive_beat(0); out_ready = 1'b1;
    #1 chk("lat_in_ready", 64'(in_ready), 64'd1);
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      in_valid = 1'b0;
    end while (!out_valid && lat < 10);
    chk("latency", 64'(lat), 64'd4);
    check_out(0, "lat");
    @(posedge clk); #1;
    chk("lat_consumed", 64'(out_valid), 64'd0);

    run_beats(1, 3, -1, 0, -1);
    run_beats(1, 6, 4, 3, -1);
    run_beats(4, 1, -1, 0, 2);
    run_beats(1, 1, -1, 0, 0);

    load_cfg(16383, 16385);
    run_beats(7, 1, -1, 0, -1);
    load_cfg(12289, 21843);

    // Reset with a full pipe: nothing in flight may survive.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k < 4);
      drive_beat(1);
    end
    #1 chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_res",   64'(out_res),   64'd0);
    chk("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("midrst_no_stale", 64'(stale), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
